sos_cascade: RTL and testbench

//  Parametrised cascade of STAGES second-order IIR sections sharing one time-multiplexed MAC.

---
 rtl/sos_cascade.sv | 164 ++++++++++++++++
 tb/tb_sos_cascade.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sos_cascade.sv
// sos_cascade: cascade of STAGES biquad sections sharing one time-multiplexed MAC,
// with double-buffered (shadow/active) runtime-loadable coefficients.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   sample_trig_i  one-cycle pulse, audio_in_i valid
//   audio_in_i     signed input sample (K bits)
//   audio_out_o    filtered sample, held until the next result
//   filter_done_o  one-cycle pulse, audio_out_o updated
//   busy_o         sample in progress
//   overrun_o      sticky, trigger arrived while busy
//   coef_we_i      write coef_wdata_i into the shadow bank
//   coef_addr_i    {stage, idx}; idx 0..4 = b0,b1,b2,a1,a2, 5..7 ignored
//   coef_wdata_i   signed coefficient (CW bits, FRAC fraction bits)
//   coef_commit_i  copy shadow bank into active bank
module sos_cascade #(
    parameter int K      = 24,
    parameter int CW     = 16,
    parameter int FRAC   = 14,
    parameter int STAGES = 2,
    localparam int AW    = $clog2(STAGES) + 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sample_trig_i,
    input  logic [K-1:0]  audio_in_i,
    output logic [K-1:0]  audio_out_o,
    output logic          filter_done_o,
    output logic          busy_o,
    output logic          overrun_o,
    input  logic          coef_we_i,
    input  logic [AW-1:0] coef_addr_i,
    input  logic [CW-1:0] coef_wdata_i,
    input  logic          coef_commit_i
);
    localparam int ACW = K + CW + 3;
    localparam int SW  = STAGES > 1 ? $clog2(STAGES) : 1;
    localparam logic signed [ACW-1:0] YMAX = ACW'((longint'(1) <<< (K - 1)) - 1);
    localparam logic signed [ACW-1:0] YMIN = -YMAX - 1;

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t                 state_q;
    logic [SW-1:0]          stage_q;
    logic [2:0]             term_q;
    logic signed [ACW-1:0]  acc_q;
    logic signed [K-1:0]    x_q;
    logic signed [K-1:0]    x1_q [STAGES];
    logic signed [K-1:0]    x2_q [STAGES];
    logic signed [K-1:0]    y1_q [STAGES];
    logic signed [K-1:0]    y2_q [STAGES];
    logic signed [CW-1:0]   shadow_q [STAGES][5];
    logic signed [CW-1:0]   active_q [STAGES][5];
    logic                   pend_q;
    logic                   overrun_q;
    logic                   busy_q;
    logic                   done_q;
    logic signed [K-1:0]    out_q;

    logic signed [CW-1:0]   coef_d;
    logic signed [K-1:0]    op_d;
    logic signed [K+CW-1:0] prod_d;
    logic signed [ACW-1:0]  acc_d;
    logic signed [ACW-1:0]  rnd_d;
    logic signed [K-1:0]    y_d;
    logic [AW-1:0]          wr_stage_d;
    logic                   copy_d;

    always_comb begin
        coef_d     = active_q[stage_q][term_q];
        op_d       = term_q == 3'd0 ? x_q :
                     term_q == 3'd1 ? x1_q[stage_q] :
                     term_q == 3'd2 ? x2_q[stage_q] :
                     term_q == 3'd3 ? y1_q[stage_q] : y2_q[stage_q];
        prod_d     = (K+CW)'(coef_d) * (K+CW)'(op_d);
        // Feedback terms (a1, a2) are subtracted.
        acc_d      = term_q == 3'd0 ? ACW'(prod_d) :
                     term_q < 3'd3  ? acc_q + ACW'(prod_d) : acc_q - ACW'(prod_d);
        rnd_d      = (acc_q + ACW'(1 << (FRAC - 1))) >>> FRAC;
        y_d        = rnd_d > YMAX ? K'(YMAX) : rnd_d < YMIN ? K'(YMIN) : K'(rnd_d);
        wr_stage_d = coef_addr_i >> 3;
        // Commit copies immediately in IDLE; a commit seen while busy waits for the DONE->IDLE edge.
        copy_d     = (coef_commit_i && state_q == IDLE) ||
                     (state_q == DONE && (pend_q || coef_commit_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            term_q    <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= '0;
            for (int s = 0; s < STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
                for (int t = 0; t < 5; t++) begin
                    shadow_q[s][t] <= CW'(t == 0 ? 1 << FRAC : 0);
                    active_q[s][t] <= CW'(t == 0 ? 1 << FRAC : 0);
                end
            end
        end else begin
            for (int s = 0; s < STAGES; s++)
                for (int t = 0; t < 5; t++)
                    if (coef_we_i && wr_stage_d == AW'(s) && coef_addr_i[2:0] == 3'(t))
                        shadow_q[s][t] <= coef_wdata_i;
            if (copy_d)
                active_q <= shadow_q;
            pend_q <= (state_q == MAC || state_q == WB) && (pend_q || coef_commit_i);
            if (sample_trig_i && state_q != IDLE)
                overrun_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (sample_trig_i) begin
                    x_q     <= audio_in_i;
                    stage_q <= '0;
                    term_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q  <= acc_d;
                    term_q <= term_q + 3'd1;
                    if (term_q == 3'd4)
                        state_q <= WB;
                end
                WB: begin
                    x2_q[stage_q] <= x1_q[stage_q];
                    x1_q[stage_q] <= x_q;
                    y2_q[stage_q] <= y1_q[stage_q];
                    y1_q[stage_q] <= y_d;
                    x_q           <= y_d;
                    term_q        <= '0;
                    if (stage_q == SW'(STAGES - 1)) begin
                        out_q   <= y_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign audio_out_o   = out_q;
    assign filter_done_o = done_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_sos_cascade.sv
// tb_sos_cascade: randomized and directed self-checking bench for sos_cascade against a
// behavioural biquad-cascade model.
module tb_sos_cascade;
    localparam int K = 24, CW = 16, FRAC = 14, STAGES = 2, AW = 4, LAT = 6 * STAGES + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 trig = 1'b0;
    logic signed [K-1:0]  ain = '0;
    logic signed [K-1:0]  aout;
    logic                 done, busy, overrun;
    logic                 we = 1'b0;
    logic [AW-1:0]        addr = '0;
    logic signed [CW-1:0] wdata = '0;
    logic                 commit = 1'b0;

    int total = 0;
    int bad = 0;

    longint sh_m [STAGES][5];
    longint ac_m [STAGES][5];
    longint hx1 [STAGES], hx2 [STAGES], hy1 [STAGES], hy2 [STAGES];
    bit     pend_m;

    sos_cascade #(.K(K), .CW(CW), .FRAC(FRAC), .STAGES(STAGES)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sample_trig_i(trig), .audio_in_i(ain),
        .audio_out_o(aout), .filter_done_o(done), .busy_o(busy), .overrun_o(overrun),
        .coef_we_i(we), .coef_addr_i(addr), .coef_wdata_i(wdata), .coef_commit_i(commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < STAGES; s++) begin
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
            for (int t = 0; t < 5; t++) begin
                sh_m[s][t] = t == 0 ? 16384 : 0;
                ac_m[s][t] = sh_m[s][t];
            end
        end
        pend_m = 0;
    endfunction

    // One sample through the whole cascade, using the active coefficients.
    function automatic longint model_step(input longint x);
        longint acc, y;
        for (int s = 0; s < STAGES; s++) begin
            acc = ac_m[s][0] * x + ac_m[s][1] * hx1[s] + ac_m[s][2] * hx2[s]
                - ac_m[s][3] * hy1[s] - ac_m[s][4] * hy2[s];
            y = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (y > 8388607) y = 8388607;
            if (y < -8388608) y = -8388608;
            hx2[s] = hx1[s]; hx1[s] = x; hy2[s] = hy1[s]; hy1[s] = y;
            x = y;
        end
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wr(input int s, input int idx, input int v, input bit with_commit);
        @(negedge clk);
        we = 1'b1;
        addr = AW'((s << 3) | idx);
        wdata = CW'(v);
        commit = with_commit;
        if (with_commit)
            ac_m = sh_m;
        if (idx < 5)
            sh_m[s][idx] = longint'(wdata);
        @(negedge clk);
        we = 1'b0;
        commit = 1'b0;
    endtask

    task automatic cmt();
        @(negedge clk);
        commit = 1'b1;
        ac_m = sh_m;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Waits for filter_done, n counts cycles since the trigger cycle.
    task automatic wait_done(inout int n);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
    endtask

    task automatic run(input longint x, input bit with_commit, input string tag);
        longint exp;
        int n;
        @(negedge clk);
        trig = 1'b1;
        ain = K'(x);
        commit = with_commit;
        if (with_commit)
            ac_m = sh_m;
        exp = model_step(x);
        @(negedge clk);
        trig = 1'b0;
        commit = 1'b0;
        n = 1;
        wait_done(n);
        check(tag, aout, exp);
    endtask

    initial begin
        longint exp;
        int n, pulses;
        model_reset();
        #12;
        check("rst_out", aout, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        do_reset();

        run(1000, 0, "passthru");
        check("passthru_const", aout, 1000);

        do_reset();
        wr(0, 0, 4096, 0);
        wr(0, 1, 4096, 0);
        wr(0, 2, 4096, 0);
        cmt();
        run(16384, 0, "imp0"); check("imp0_c", aout, 4096);
        run(0, 0, "imp1");     check("imp1_c", aout, 4096);
        run(0, 0, "imp2");     check("imp2_c", aout, 4096);
        run(0, 0, "imp3");     check("imp3_c", aout, 0);

        do_reset();
        wr(0, 0, 32767, 0);
        cmt();
        run(8388607, 0, "satp");  check("satp_c", aout, 8388607);
        run(-8388608, 0, "satn"); check("satn_c", aout, -8388608);

        // Second trigger while busy is dropped and flagged.
        do_reset();
        @(negedge clk);
        trig = 1'b1;
        ain = 100;
        exp = model_step(100);
        @(negedge clk);
        trig = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        trig = 1'b1;
        ain = 777;
        @(negedge clk);
        trig = 1'b0;
        n++;
        check("ovr_flag", overrun, 1);
        check("ovr_busy", busy, 1);
        wait_done(n);
        check("ovr_out", aout, exp);
        pulses = 0;
        repeat (20) begin @(negedge clk); pulses += done; end
        check("ovr_extra_done", pulses, 0);
        check("ovr_idle", busy, 0);
        check("ovr_sticky", overrun, 1);

        // Commit issued mid-sample takes effect only for the next sample.
        do_reset();
        wr(0, 0, 8192, 0);
        @(negedge clk);
        trig = 1'b1;
        ain = 2000;
        exp = model_step(2000);
        @(negedge clk);
        trig = 1'b0;
        n = 1;
        repeat (2) begin @(negedge clk); n++; end
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        n++;
        wait_done(n);
        check("pend_cur", aout, exp);
        check("pend_cur_c", aout, 2000);
        ac_m = sh_m;
        run(2000, 0, "pend_next"); check("pend_next_c", aout, 1000);

        // A write in the commit cycle is not part of that copy.
        wr(0, 0, 4096, 1);
        run(4000, 0, "wc_same"); check("wc_same_c", aout, 2000);
        cmt();
        run(4000, 0, "wc_after"); check("wc_after_c", aout, 1000);

        // Commit together with trigger applies to that very sample.
        wr(0, 0, 2048, 0);
        run(8000, 1, "ct_same"); check("ct_same_c", aout, 1000);

        // Randomized coefficients, commits and samples.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int s = $urandom_range(0, STAGES - 1);
                int idx = $urandom_range(0, 7);
                int v = idx < 3 ? $urandom_range(0, 24000) - 12000 : $urandom_range(0, 12000) - 6000;
                wr(s, idx, v, $urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 3) == 0)
                cmt();
            run(longint'($urandom_range(0, 2000000)) - 1000000, $urandom_range(0, 5) == 0, "rand");
        end

        // Asynchronous reset in the middle of a sample.
        @(negedge clk);
        trig = 1'b1;
        ain = 300000;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_ovr", overrun, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", aout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(500, 0, "after_rst"); check("after_rst_c", aout, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
